// File: rtl/vram_swap_ctrl.sv
// vram_swap_ctrl: commits a CPU frame to the double-buffered VRAM at vblank,
// then copies the newly displayed buffer back into the CPU-side buffer.
// The CPU-side write port is shared between CPU writes and the copy engine.
// Optional build macro: VRAM_SWAP_IRQ_EN adds irq / irq_ack ports.
module vram_swap_ctrl #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned COPY_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              swap_req,
  input  logic              vblank,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wrdata,
  input  logic              cpu_wren,
  input  logic              clr_dropped,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_rddata,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] dst_wrdata,
  output logic              dst_wren,
  output logic              swap,
  output logic              busy,
  output logic              swap_done,
  output logic [15:0]       frame_cnt,
`ifdef VRAM_SWAP_IRQ_EN
  output logic              irq,
  input  logic              irq_ack,
`endif
  output logic              cpu_wr_dropped
);

  // One extra bit so a full 2**ADDR_W copy can still reach its terminal count
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COPY_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_SWAP  = 3'd2,
    S_COPY  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]  rd;
  logic              pending;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              swap_q;
  logic              busy_q;
  logic              done_q;
  logic [15:0]       frame_q;
  logic              dropped_q;
  logic              copy_own;
  logic              drop;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (swap_req) next_state = S_ARMED;
      S_ARMED: if (vblank)   next_state = S_SWAP;
      S_SWAP:  next_state = S_COPY;
      S_COPY:  if (rd == LAST_CNT) next_state = S_DONE;
      S_DONE:  next_state = (pending || swap_req) ? S_ARMED : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Write-port arbitration: CPU passes through unless the copy engine owns the port
  always_comb begin
    copy_own   = 1'b0;
    dst_addr   = cpu_addr;
    dst_wrdata = cpu_wrdata;
    dst_wren   = cpu_wren;
    case (state)
      S_SWAP, S_COPY, S_DONE: begin
        copy_own   = 1'b1;
        dst_addr   = wr_addr_q;
        dst_wrdata = src_rddata;
        dst_wren   = wr_en_q;
      end
      default: ;
    endcase
    drop = cpu_wren && copy_own;
  end

  // Copy engine: read stage drives src_addr, write stage lags one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd        <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      if (state == S_COPY && rd != LAST_CNT) rd <= rd + CNT_W'(1);
      else                                   rd <= '0;
      wr_en_q   <= (state == S_COPY) && (rd != LAST_CNT);
      wr_addr_q <= rd[ADDR_W-1:0];
    end
  end

  // Status outputs, frame counter, pending request and drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      frame_q   <= '0;
      pending   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      swap_q <= (next_state == S_SWAP);
      busy_q <= (next_state != S_IDLE);
      done_q <= (next_state == S_DONE);
      if (next_state == S_DONE && state != S_DONE) frame_q <= frame_q + 16'd1;
      if (state == S_DONE)              pending <= 1'b0;
      else if (swap_req && copy_own)    pending <= 1'b1;
      if (drop)             dropped_q <= 1'b1;
      else if (clr_dropped) dropped_q <= 1'b0;
    end
  end

`ifdef VRAM_SWAP_IRQ_EN
  logic irq_q;

  // Completion interrupt: set after swap_done, held until acknowledged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       irq_q <= 1'b0;
    else if (done_q)  irq_q <= 1'b1;
    else if (irq_ack) irq_q <= 1'b0;
  end

  assign irq = irq_q;
`endif

  assign src_addr       = rd[ADDR_W-1:0];
  assign swap           = swap_q;
  assign busy           = busy_q;
  assign swap_done      = done_q;
  assign frame_cnt      = frame_q;
  assign cpu_wr_dropped = dropped_q;

endmodule

// File: tb/tb_vram_swap_ctrl.sv
// Directed bench for vram_swap_ctrl with a 16-word region.
module tb_vram_swap_ctrl;

  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned COPY_DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              swap_req, vblank, cpu_wren, clr_dropped;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wrdata;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [DATA_W-1:0] src_rddata, dst_wrdata;
  logic              dst_wren, swap, busy, swap_done, cpu_wr_dropped;
  logic [15:0]       frame_cnt;
`ifdef VRAM_SWAP_IRQ_EN
  logic              irq, irq_ack;
`endif

  vram_swap_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .COPY_DEPTH(COPY_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .swap_req(swap_req), .vblank(vblank),
    .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_wren(cpu_wren),
    .clr_dropped(clr_dropped), .src_addr(src_addr), .src_rddata(src_rddata),
    .dst_addr(dst_addr), .dst_wrdata(dst_wrdata), .dst_wren(dst_wren),
    .swap(swap), .busy(busy), .swap_done(swap_done), .frame_cnt(frame_cnt),
`ifdef VRAM_SWAP_IRQ_EN
    .irq(irq), .irq_ack(irq_ack),
`endif
    .cpu_wr_dropped(cpu_wr_dropped)
  );

  always #5 clk = ~clk;

  // PPU-side buffer model: synchronous read, data[i] = 0xA000 + i
  logic [DATA_W-1:0] src_mem [COPY_DEPTH];
  initial for (int i = 0; i < int'(COPY_DEPTH); i++) src_mem[i] = 32'hA000 + 32'(i);
  always @(posedge clk) src_rddata <= src_mem[src_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Log of writes seen on dst while the controller is busy
  int                log_n = 0;
  logic [ADDR_W-1:0] log_addr [256];
  logic [DATA_W-1:0] log_data [256];
  int                log_cyc  [256];
  int                dead_seen = 0;
  int                swap_cnt  = 0;
  always @(negedge clk) begin
    if (busy && dst_wren && log_n < 256) begin
      log_addr[log_n] = dst_addr;
      log_data[log_n] = dst_wrdata;
      log_cyc[log_n]  = cyc;
      if (dst_wrdata == 32'hDEAD) dead_seen = dead_seen + 1;
      log_n = log_n + 1;
    end
    if (swap) swap_cnt = swap_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
  endtask

  task automatic pulse_vblank();
    vblank = 1'b1; tick(); vblank = 1'b0;
  endtask

  // Advance until swap_done is seen, bounded
  task automatic wait_done(input string tag, output int done_cyc);
    bit seen = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (swap_done) begin seen = 1'b1; done_cyc = cyc; end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  int base, dc, s0;
  bit ok;

  initial begin
    rst_n = 1'b0; swap_req = 1'b0; vblank = 1'b0; cpu_wren = 1'b0;
    clr_dropped = 1'b0; cpu_addr = '0; cpu_wrdata = '0;
`ifdef VRAM_SWAP_IRQ_EN
    irq_ack = 1'b0;
`endif
    repeat (3) tick();
    check("rst_swap",    32'(swap), 0);
    check("rst_busy",    32'(busy), 0);
    check("rst_done",    32'(swap_done), 0);
    check("rst_wren",    32'(dst_wren), 0);
    check("rst_dropped", 32'(cpu_wr_dropped), 0);
    check("rst_frame",   32'(frame_cnt), 0);
    check("rst_src",     32'(src_addr), 0);
    rst_n = 1'b1;
    tick();

    // Commit and copy
    base = log_n;
    pulse_req();
    check("t1_armed_busy", 32'(busy), 1);
    repeat (19) tick();
    check("t1_no_early_swap", 32'(swap), 0);
    pulse_vblank();
    check("t1_swap_hi", 32'(swap), 1);
    tick();
    check("t1_swap_lo", 32'(swap), 0);
    wait_done("t1", dc);
    check("t1_nwrites", 32'(log_n - base), 16);
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (log_addr[base+i] !== 4'(i) || log_data[base+i] !== 32'hA000 + 32'(i)) ok = 1'b0;
    end
    check("t1_addr_data", 32'(ok), 1);
    check("t1_consecutive", 32'(log_cyc[base+15] - log_cyc[base]), 15);
    check("t1_done_lag", 32'(dc - log_cyc[base+15]), 1);
    check("t1_frame", 32'(frame_cnt), 1);
    tick();
    check("t1_done_pulse", 32'(swap_done), 0);
    check("t1_idle", 32'(busy), 0);

    // Coalescing of repeated requests
    s0 = swap_cnt;
    pulse_req(); tick(); pulse_req(); pulse_req(); repeat (3) tick();
    pulse_vblank();
    wait_done("t2", dc);
    check("t2_frame", 32'(frame_cnt), 2);
    tick();
    check("t2_idle", 32'(busy), 0);
    check("t2_one_swap", 32'(swap_cnt - s0), 1);

    // Request arriving during the copy
    pulse_req(); tick();
    pulse_vblank();                 // now in SWAP
    repeat (6) tick();              // copy word 5 being read
    check("t3_src5", 32'(src_addr), 5);
    pulse_req();
    wait_done("t3a", dc);
    check("t3_frame_a", 32'(frame_cnt), 3);
    tick();
    check("t3_rearmed", 32'(busy), 1);
    check("t3_no_swap_yet", 32'(swap), 0);
    pulse_vblank();
    check("t3_swap2", 32'(swap), 1);
    wait_done("t3b", dc);
    check("t3_frame_b", 32'(frame_cnt), 4);
    tick();
    check("t3_idle", 32'(busy), 0);

    // Simultaneous request and vblank in IDLE
    swap_req = 1'b1; vblank = 1'b1; tick(); swap_req = 1'b0; vblank = 1'b0;
    check("t4_armed", 32'(busy), 1);
    check("t4_no_swap", 32'(swap), 0);
    tick();
    check("t4_no_swap2", 32'(swap), 0);
    pulse_vblank();
    check("t4_swap", 32'(swap), 1);
    wait_done("t4", dc);
    check("t4_frame", 32'(frame_cnt), 5);
    tick();

    // CPU write during copy is dropped; in IDLE it passes through
    dead_seen = 0;
    pulse_req(); pulse_vblank(); repeat (4) tick();
    cpu_addr = 4'd3; cpu_wrdata = 32'hDEAD; cpu_wren = 1'b1;
    #1;
    check("t5_copy_owns", 32'(dst_wrdata == 32'hDEAD), 0);
    tick();
    cpu_wren = 1'b0;
    check("t5_dropped", 32'(cpu_wr_dropped), 1);
    wait_done("t5", dc);
    tick();
    check("t5_never_dead", 32'(dead_seen), 0);
    check("t5_sticky", 32'(cpu_wr_dropped), 1);
    cpu_wren = 1'b1;
    #1;
    check("t5_pass_wren", 32'(dst_wren), 1);
    check("t5_pass_addr", 32'(dst_addr), 3);
    check("t5_pass_data", dst_wrdata, 32'hDEAD);
    cpu_wren = 1'b0;
    clr_dropped = 1'b1; tick(); clr_dropped = 1'b0;
    check("t5_cleared", 32'(cpu_wr_dropped), 0);
    check("t5_frame", 32'(frame_cnt), 6);

    // Asynchronous reset in the middle of a copy
    pulse_req(); pulse_vblank(); repeat (8) tick();
    check("t6_src7", 32'(src_addr), 7);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy",  32'(busy), 0);
    check("t6_wren",  32'(dst_wren), 0);
    check("t6_swap",  32'(swap), 0);
    check("t6_frame", 32'(frame_cnt), 0);
    check("t6_src",   32'(src_addr), 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("t6_idle", 32'(busy), 0);
    check("t6_frame_after", 32'(frame_cnt), 0);

`ifdef VRAM_SWAP_IRQ_EN
    check("irq_rst", 32'(irq), 0);
    pulse_req(); pulse_vblank();
    wait_done("irq", dc);
    check("irq_not_yet", 32'(irq), 0);
    tick();
    check("irq_set", 32'(irq), 1);
    tick();
    check("irq_held", 32'(irq), 1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("irq_cleared", 32'(irq), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
